// File: rtl/st_frame_sched.sv
// rtl/st_frame_sched.sv - ST-bus frame scheduler: f0 lock, channel/bit decode, shift strobe, frame interrupt
// Optional build macro ST_FRAME_ERR_CNT_EN adds the err_cnt output (bad/missing f0 tally).
module st_frame_sched #(
   parameter int CHANNELS    = 32,
   parameter int LOCK_FRAMES = 2,
   parameter int LOSS_FRAMES = 2,
   parameter int INT_DIV     = 8,
   parameter int WIN_START   = 0,
   parameter int WIN_LEN     = 24
) (
   input  logic       c4,
   input  logic       reset_rg,
   input  logic       f0,
   input  logic       int_ack,
   output logic       bit_clk,
   output logic [4:0] chan_num,
   output logic [2:0] bit_num,
   output logic       frame_start,
   output logic       win_active,
   output logic       shift_en,
   output logic       locked,
   output logic       cpu_int,
`ifdef ST_FRAME_ERR_CNT_EN
   output logic [7:0] err_cnt,
`endif
   output logic       int_ovr
);

   localparam int FRAME_C4 = CHANNELS * 16;
   localparam int FRM_W    = (INT_DIV > 1) ? $clog2(INT_DIV) : 1;

   localparam logic [8:0]       CNT_LAST    = 9'(FRAME_C4 - 1);
   localparam logic [FRM_W-1:0] FRM_LAST    = FRM_W'(INT_DIV - 1);
   localparam logic [7:0]       GOOD_TGT    = 8'(LOCK_FRAMES);
   localparam logic [7:0]       MISS_TGT    = 8'(LOSS_FRAMES);
   localparam logic [31:0]      WIN_START_U = WIN_START;
   localparam logic [31:0]      WIN_LEN_U   = WIN_LEN;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } sync_state_t;

   sync_state_t      state_q, state_d;
   logic             f0_q;
   logic [8:0]       cnt_q, cnt_d;
   logic [7:0]       good_q, good_d;
   logic [7:0]       miss_q, miss_d;
   logic [FRM_W-1:0] frm_q, frm_d;
   logic             cpu_int_q, cpu_int_d;
   logic             int_ovr_q, int_ovr_d;
   logic             bit_clk_q, bit_clk_d;
   logic [4:0]       chan_num_q, chan_num_d;
   logic [2:0]       bit_num_q, bit_num_d;
   logic             frame_start_q, frame_start_d;
   logic             win_active_q, win_active_d;
   logic             shift_en_q, shift_en_d;
   logic             locked_q, locked_d;

   logic             fe, cnt_last, good_ev, bad_ev, miss_ev, frame_end, int_evt;
   logic [31:0]      win_off;

   // Frame event is a sampled falling edge of f0; classify it against the flywheel position
   always_comb begin
      fe        = !f0 && f0_q;
      cnt_last  = (cnt_q == CNT_LAST);
      good_ev   = fe && cnt_last;
      bad_ev    = fe && !cnt_last;
      miss_ev   = !fe && cnt_last;
      frame_end = fe || cnt_last;
      cnt_d     = frame_end ? 9'd0 : cnt_q + 9'd1;
   end

   // Sync FSM: hunt for any f0, qualify spacing, then ride through isolated faults while locked
   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      miss_d  = miss_q;
      case (state_q)
         HUNT: begin
            if (fe) begin
               state_d = CHECK;
               good_d  = 8'd0;
            end
         end
         CHECK: begin
            if (good_ev) begin
               if (good_q + 8'd1 >= GOOD_TGT) begin
                  state_d = LOCKED;
                  good_d  = 8'd0;
                  miss_d  = 8'd0;
               end else begin
                  good_d = good_q + 8'd1;
               end
            end else if (bad_ev) begin
               good_d = 8'd0;
            end else if (miss_ev) begin
               state_d = HUNT;
               good_d  = 8'd0;
            end
         end
         LOCKED: begin
            if (good_ev) begin
               miss_d = 8'd0;
            end else if (bad_ev || miss_ev) begin
               if (miss_q + 8'd1 >= MISS_TGT) begin
                  state_d = HUNT;
                  miss_d  = 8'd0;
               end else begin
                  miss_d = miss_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = HUNT;
            good_d  = 8'd0;
            miss_d  = 8'd0;
         end
      endcase
   end

   // Frame divider and interrupt request; an event coinciding with int_ack keeps the request but drops overrun
   always_comb begin
      int_evt = (state_q == LOCKED) && frame_end && (frm_q == FRM_LAST);
      if (state_d != LOCKED) begin
         frm_d = '0;
      end else if ((state_q == LOCKED) && frame_end) begin
         frm_d = (frm_q == FRM_LAST) ? '0 : frm_q + FRM_W'(1);
      end else begin
         frm_d = frm_q;
      end
      cpu_int_d = int_evt || (cpu_int_q && !int_ack);
      int_ovr_d = !int_ack && (int_ovr_q || (int_evt && cpu_int_q));
   end

   // Output decode from the next counter/state so registered outputs line up with cnt
   always_comb begin
      win_off       = 32'(cnt_d[8:4]) - WIN_START_U;
      bit_clk_d     = ~cnt_d[0];
      chan_num_d    = cnt_d[8:4];
      bit_num_d     = cnt_d[3:1];
      frame_start_d = (cnt_d == 9'd0);
      win_active_d  = (win_off < WIN_LEN_U);
      locked_d      = (state_d == LOCKED);
      shift_en_d    = locked_d && win_active_d && cnt_d[0];
   end

`ifdef ST_FRAME_ERR_CNT_EN
   logic [7:0] err_q, err_d;

   // Saturating tally of bad or missing f0 while qualifying or locked; cleared with the interrupt ack
   always_comb begin
      err_d = err_q;
      if (int_ack) begin
         err_d = 8'd0;
      end else if ((state_q != HUNT) && (bad_ev || miss_ev) && (err_q != 8'hFF)) begin
         err_d = err_q + 8'd1;
      end
   end

   assign err_cnt = err_q;
`endif

   // All state and registered outputs
   always_ff @(posedge c4 or negedge reset_rg) begin
      if (!reset_rg) begin
         state_q       <= HUNT;
         f0_q          <= 1'b1;
         cnt_q         <= 9'd0;
         good_q        <= 8'd0;
         miss_q        <= 8'd0;
         frm_q         <= '0;
         cpu_int_q     <= 1'b0;
         int_ovr_q     <= 1'b0;
         bit_clk_q     <= 1'b1;
         chan_num_q    <= 5'd0;
         bit_num_q     <= 3'd0;
         frame_start_q <= 1'b0;
         win_active_q  <= 1'b0;
         shift_en_q    <= 1'b0;
         locked_q      <= 1'b0;
`ifdef ST_FRAME_ERR_CNT_EN
         err_q         <= 8'd0;
`endif
      end else begin
         state_q       <= state_d;
         f0_q          <= f0;
         cnt_q         <= cnt_d;
         good_q        <= good_d;
         miss_q        <= miss_d;
         frm_q         <= frm_d;
         cpu_int_q     <= cpu_int_d;
         int_ovr_q     <= int_ovr_d;
         bit_clk_q     <= bit_clk_d;
         chan_num_q    <= chan_num_d;
         bit_num_q     <= bit_num_d;
         frame_start_q <= frame_start_d;
         win_active_q  <= win_active_d;
         shift_en_q    <= shift_en_d;
         locked_q      <= locked_d;
`ifdef ST_FRAME_ERR_CNT_EN
         err_q         <= err_d;
`endif
      end
   end

   assign bit_clk     = bit_clk_q;
   assign chan_num    = chan_num_q;
   assign bit_num     = bit_num_q;
   assign frame_start = frame_start_q;
   assign win_active  = win_active_q;
   assign shift_en    = shift_en_q;
   assign locked      = locked_q;
   assign cpu_int     = cpu_int_q;
   assign int_ovr     = int_ovr_q;

endmodule

// File: tb/tb_st_frame_sched.sv
// tb/tb_st_frame_sched.sv - self-checking bench for st_frame_sched with a frame-level reference model
module tb_st_frame_sched;

   localparam int FRAME_C4    = 512;
   localparam int LOCK_FRAMES = 2;
   localparam int LOSS_FRAMES = 2;
   localparam int INT_DIV     = 8;
   localparam int WIN_START   = 0;
   localparam int WIN_LEN     = 24;

   logic       c4 = 1'b0;
   logic       reset_rg = 1'b1;
   logic       f0 = 1'b1;
   logic       int_ack = 1'b0;
   logic       bit_clk, frame_start, win_active, shift_en, locked, cpu_int, int_ovr;
   logic [4:0] chan_num;
   logic [2:0] bit_num;
`ifdef ST_FRAME_ERR_CNT_EN
   logic [7:0] err_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: frame position, sync mode (0 hunt, 1 check, 2 locked) and interrupt bookkeeping
   int          m_cnt, m_mode, m_good, m_miss, m_frames, m_err;
   logic        m_f0p, m_int, m_ovr;
   logic [14:0] m_exp;

   always #5 c4 = ~c4;

   st_frame_sched dut (
      .c4          (c4),
      .reset_rg    (reset_rg),
      .f0          (f0),
      .int_ack     (int_ack),
      .bit_clk     (bit_clk),
      .chan_num    (chan_num),
      .bit_num     (bit_num),
      .frame_start (frame_start),
      .win_active  (win_active),
      .shift_en    (shift_en),
      .locked      (locked),
      .cpu_int     (cpu_int),
`ifdef ST_FRAME_ERR_CNT_EN
      .err_cnt     (err_cnt),
`endif
      .int_ovr     (int_ovr)
   );

   task automatic model_reset();
      m_cnt = 0; m_mode = 0; m_good = 0; m_miss = 0; m_frames = 0; m_err = 0;
      m_f0p = 1'b1; m_int = 1'b0; m_ovr = 1'b0;
      m_exp = {1'b1, 14'd0};
   endtask

   task automatic model_step(input logic f0v, input logic ackv);
      bit fe, last, good, bad, miss, was_locked, evt, win;
      int mode_before, chan;
      fe          = (f0v == 1'b0) && (m_f0p == 1'b1);
      m_f0p       = f0v;
      last        = (m_cnt == FRAME_C4 - 1);
      good        = fe && last;
      bad         = fe && !last;
      miss        = !fe && last;
      mode_before = m_mode;
      was_locked  = (m_mode == 2);
      if (m_mode == 0) begin
         if (fe) begin m_mode = 1; m_good = 0; end
      end else if (m_mode == 1) begin
         if (good) begin
            m_good++;
            if (m_good >= LOCK_FRAMES) begin m_mode = 2; m_miss = 0; m_good = 0; end
         end else if (bad) m_good = 0;
         else if (miss) m_mode = 0;
      end else begin
         if (good) m_miss = 0;
         else if (bad || miss) begin
            m_miss++;
            if (m_miss >= LOSS_FRAMES) begin m_mode = 0; m_miss = 0; end
         end
      end
      if (ackv) m_err = 0;
      else if (mode_before != 0 && (bad || miss) && m_err < 255) m_err++;
      evt = 0;
      if (was_locked && (fe || last)) begin
         m_frames++;
         if (m_frames == INT_DIV) begin m_frames = 0; evt = 1; end
      end
      if (m_mode != 2) m_frames = 0;
      if (ackv) m_ovr = 1'b0;
      if (evt && m_int && !ackv) m_ovr = 1'b1;
      m_int = evt ? 1'b1 : (ackv ? 1'b0 : m_int);
      m_cnt = fe ? 0 : (m_cnt + 1) % FRAME_C4;
      chan  = m_cnt / 16;
      win   = (chan >= WIN_START) && (chan < WIN_START + WIN_LEN);
      m_exp = {(m_cnt % 2 == 0), 5'(chan), 3'((m_cnt % 16) / 2), (m_cnt == 0), win,
               (m_mode == 2 && win && (m_cnt % 2 == 1)), (m_mode == 2), m_int, m_ovr};
   endtask

   task automatic tick(input logic f0v, input logic ackv);
      f0      = f0v;
      int_ack = ackv;
      @(posedge c4);
      model_step(f0v, ackv);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, 1'b0);
   endtask

   task automatic test_reset();
      reset_rg = 1'b1;
      #1 reset_rg = 1'b0;
      model_reset();
      #2;
      n_checks++; if (bit_clk !== 1'b1) begin n_fail++; $display("FAIL reset_bit_clk: got %b want 1", bit_clk); end
      n_checks++; if (chan_num !== 5'd0) begin n_fail++; $display("FAIL reset_chan_num: got %0d want 0", chan_num); end
      n_checks++; if (bit_num !== 3'd0) begin n_fail++; $display("FAIL reset_bit_num: got %0d want 0", bit_num); end
      n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
      n_checks++; if (win_active !== 1'b0) begin n_fail++; $display("FAIL reset_win_active: got %b want 0", win_active); end
      n_checks++; if (shift_en !== 1'b0) begin n_fail++; $display("FAIL reset_shift_en: got %b want 0", shift_en); end
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
      n_checks++; if (cpu_int !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_int: got %b want 0", cpu_int); end
      n_checks++; if (int_ovr !== 1'b0) begin n_fail++; $display("FAIL reset_int_ovr: got %b want 0", int_ovr); end
`ifdef ST_FRAME_ERR_CNT_EN
      n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
`endif
      @(posedge c4);
      #1 reset_rg = 1'b1;
   endtask

   task automatic test_lock();
      int bad = 0;
      idle(5);
      tick(1'b0, 1'b0);
      n_checks++;
      if (locked !== 1'b0 || frame_start !== 1'b1) begin
         n_fail++; $display("FAIL lock_pulse1: locked=%b frame_start=%b want 0/1", locked, frame_start);
      end
      idle(FRAME_C4 - 1);
      tick(1'b0, 1'b0);
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_pulse2: locked=%b want 0", locked); end
      idle(FRAME_C4 - 1);
      tick(1'b0, 1'b0);
      n_checks++;
      if (locked !== 1'b1 || frame_start !== 1'b1) begin
         n_fail++; $display("FAIL lock_pulse3: locked=%b frame_start=%b want 1/1", locked, frame_start);
      end
      for (int j = 1; j < FRAME_C4; j++) begin
         tick(1'b1, 1'b0);
         n_checks++;
         if (chan_num !== 5'(j / 16) || bit_num !== 3'((j % 16) / 2) || bit_clk !== (j % 2 == 0) || frame_start !== 1'b0) begin
            n_fail++;
            if (bad < 4) $display("FAIL lock_decode cnt=%0d: chan=%0d bit=%0d bclk=%b fs=%b want %0d/%0d/%0b/0",
                                  j, chan_num, bit_num, bit_clk, frame_start, j / 16, (j % 16) / 2, (j % 2 == 0));
            bad++;
         end
      end
   endtask

   task automatic test_shift_window();
      int count = 0, first = -1, last = -1, even_hits = 0;
      tick(1'b0, 1'b0);
      n_checks++;
      if (frame_start !== 1'b1 || shift_en !== 1'b0) begin
         n_fail++; $display("FAIL shift_frame0: frame_start=%b shift_en=%b want 1/0", frame_start, shift_en);
      end
      for (int j = 1; j < FRAME_C4; j++) begin
         tick(1'b1, 1'b0);
         if (shift_en === 1'b1) begin
            count++;
            if (first < 0) first = j;
            last = j;
            if (j % 2 == 0) even_hits++;
         end
      end
      n_checks++; if (count != WIN_LEN * 8) begin n_fail++; $display("FAIL shift_count: got %0d want %0d", count, WIN_LEN * 8); end
      n_checks++; if (first != 1) begin n_fail++; $display("FAIL shift_first: got cnt %0d want 1", first); end
      n_checks++; if (last != WIN_LEN * 16 - 1) begin n_fail++; $display("FAIL shift_last: got cnt %0d want %0d", last, WIN_LEN * 16 - 1); end
      n_checks++; if (even_hits != 0) begin n_fail++; $display("FAIL shift_even: got %0d strobes at even cnt want 0", even_hits); end
   endtask

   // one locked frame end already happened in test_shift_window, so frame k here is locked frame end k+1
   task automatic test_interrupt();
      logic want_int, want_ovr;
      for (int k = 1; k <= 23; k++) begin
         tick(1'b0, (k == 23) ? 1'b1 : 1'b0);
         want_int = ((k + 1) >= INT_DIV);
         want_ovr = ((k + 1) >= 2 * INT_DIV) && (k != 23);
         n_checks++;
         if (cpu_int !== want_int || int_ovr !== want_ovr) begin
            n_fail++; $display("FAIL int_frame%0d: cpu_int=%b int_ovr=%b want %b/%b", k + 1, cpu_int, int_ovr, want_int, want_ovr);
         end
         if (k < 23) idle(FRAME_C4 - 1);
      end
      tick(1'b1, 1'b1);
      n_checks++;
      if (cpu_int !== 1'b0 || int_ovr !== 1'b0) begin
         n_fail++; $display("FAIL int_ack_clear: cpu_int=%b int_ovr=%b want 0/0", cpu_int, int_ovr);
      end
      idle(FRAME_C4 - 2);
   endtask

   task automatic test_flywheel();
      idle(1);
      n_checks++;
      if (locked !== 1'b1 || frame_start !== 1'b1) begin
         n_fail++; $display("FAIL fly_one_miss: locked=%b frame_start=%b want 1/1", locked, frame_start);
      end
      idle(FRAME_C4 - 1);
      tick(1'b0, 1'b0);
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL fly_recover: locked=%b want 1", locked); end
      idle(FRAME_C4 - 1);
      idle(1);
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL fly_miss1: locked=%b want 1", locked); end
      idle(FRAME_C4 - 1);
      idle(1);
      n_checks++;
      if (locked !== 1'b0 || shift_en !== 1'b0 || frame_start !== 1'b1) begin
         n_fail++; $display("FAIL fly_miss2: locked=%b shift_en=%b frame_start=%b want 0/0/1", locked, shift_en, frame_start);
      end
      idle(1);
      n_checks++; if (shift_en !== 1'b0) begin n_fail++; $display("FAIL fly_shift_stop: shift_en=%b want 0", shift_en); end
   endtask

   task automatic test_realign();
      tick(1'b0, 1'b0);
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL realign_hunt: locked=%b want 0", locked); end
      idle(FRAME_C4 - 1);
      tick(1'b0, 1'b0);
      idle(FRAME_C4 - 1);
      tick(1'b0, 1'b0);
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL realign_relock: locked=%b want 1", locked); end
      idle(99);
      tick(1'b1, 1'b1);
      tick(1'b0, 1'b0);
      n_checks++;
      if (locked !== 1'b1 || frame_start !== 1'b1 || chan_num !== 5'd0 || bit_clk !== 1'b1) begin
         n_fail++; $display("FAIL realign_bad_fe: locked=%b fs=%b chan=%0d bclk=%b want 1/1/0/1", locked, frame_start, chan_num, bit_clk);
      end
`ifdef ST_FRAME_ERR_CNT_EN
      n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL realign_err_cnt: got %0d want 1", err_cnt); end
`endif
   endtask

   task automatic test_random();
      int ph = 0, low_left = 0, bad = 0;
      logic f0v, ackv;
      logic [14:0] obs;
      for (int cyc = 0; cyc < 6000; cyc++) begin
         f0v = 1'b1;
         if (low_left > 0) begin
            f0v = 1'b0; low_left--;
         end else if (ph == FRAME_C4 - 1 && $urandom_range(0, 9) != 0) begin
            f0v = 1'b0; low_left = $urandom_range(0, 2);
         end else if ($urandom_range(0, 999) == 0) begin
            f0v = 1'b0;
         end
         ph   = (ph + 1) % FRAME_C4;
         ackv = ($urandom_range(0, 199) == 0);
         tick(f0v, ackv);
         obs = {bit_clk, chan_num, bit_num, frame_start, win_active, shift_en, locked, cpu_int, int_ovr};
         n_checks++;
         if (obs !== m_exp) begin
            n_fail++;
            if (bad < 5) $display("FAIL random_outputs cyc=%0d: got %h want %h", cyc, obs, m_exp);
            bad++;
         end
`ifdef ST_FRAME_ERR_CNT_EN
         n_checks++;
         if (err_cnt !== 8'(m_err)) begin
            n_fail++;
            if (bad < 5) $display("FAIL random_err_cnt cyc=%0d: got %0d want %0d", cyc, err_cnt, m_err);
            bad++;
         end
`endif
      end
   endtask

   task automatic test_reset_mid_frame();
      reset_rg = 1'b0;
      model_reset();
      @(posedge c4);
      #1 reset_rg = 1'b1;
      idle(3);
      tick(1'b0, 1'b0);
      for (int p = 0; p < 2 + INT_DIV; p++) begin
         idle(FRAME_C4 - 1);
         tick(1'b0, 1'b0);
      end
      n_checks++; if (cpu_int !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_int: cpu_int=%b want 1", cpu_int); end
      idle(200);
      reset_rg = 1'b0;
      model_reset();
      #2;
      n_checks++;
      if ({bit_clk, chan_num, bit_num, frame_start, win_active, shift_en, locked, cpu_int, int_ovr} !== {1'b1, 14'd0}) begin
         n_fail++; $display("FAIL midreset_async: bclk=%b chan=%0d bit=%0d fs=%b win=%b sh=%b lk=%b int=%b ovr=%b want 1/0...",
                            bit_clk, chan_num, bit_num, frame_start, win_active, shift_en, locked, cpu_int, int_ovr);
      end
      reset_rg = 1'b1;
      idle(3);
      tick(1'b0, 1'b0);
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL midreset_p1: locked=%b want 0", locked); end
      idle(FRAME_C4 - 1);
      tick(1'b0, 1'b0);
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL midreset_p2: locked=%b want 0", locked); end
      idle(FRAME_C4 - 1);
      tick(1'b0, 1'b0);
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL midreset_p3: locked=%b want 1", locked); end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_lock();
      test_shift_window();
      test_interrupt();
      test_flywheel();
      test_realign();
      test_random();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/st_frame_sched.md
Name: st_frame_sched

Overview:
- Frame scheduler for the ST-bus side of the converter, clocked by c4 (4.096 MHz, 512 c4 cycles per 125 us frame).
- Locks to the f0 frame pulse and flywheels through missing pulses.
- Decodes channel and bit position in the frame.
- Drives the per-bit shift strobe for the STM/DT serial window.
- Raises cpu_int every INT_DIV frames, held until int_ack.

Parameters:
CHANNELS, 32, channels per frame; frame length FRAME_C4 = CHANNELS*16 c4 cycles
LOCK_FRAMES, 2, consecutive correctly spaced f0 pulses needed to enter LOCKED
LOSS_FRAMES, 2, consecutive bad or missing f0 pulses that drop LOCKED back to HUNT
INT_DIV, 8, frames per cpu_int event
WIN_START, 0, first channel of the shift window
WIN_LEN, 24, number of channels in the shift window

Ports:
c4  in  1  sequencing clock, all logic on posedge
reset_rg  in  1  asynchronous, active-low reset
f0  in  1  frame pulse, active low, synchronous to c4
int_ack  in  1  CPU interrupt acknowledge, level sampled on posedge c4
bit_clk  out  1  high on even cnt values, low on odd
chan_num  out  5  current channel (cnt[8:4])
bit_num  out  3  current bit within channel (cnt[3:1])
frame_start  out  1  high for the single cycle where cnt==0
win_active  out  1  chan_num within [WIN_START, WIN_START+WIN_LEN-1]
shift_en  out  1  one-cycle strobe per bit inside the window while locked
locked  out  1  sync FSM in LOCKED
cpu_int  out  1  interrupt request, level
int_ovr  out  1  sticky: interrupt event while cpu_int was already pending

Behaviour:
- Reset (reset_rg=0): cnt=0, f0_q=1, state=HUNT, good_cnt=0, miss_cnt=0, frm_cnt=0; all outputs 0 except bit_clk=1 (cnt=0 is even).
- Frame event (fe) = f0==0 && f0_q==1, i.e. a sampled falling edge. A low level held over several cycles counts once.
- cnt is 9 bits. On fe, cnt<=0. Otherwise cnt<=cnt+1, wrapping FRAME_C4-1 -> 0 (flywheel).
- Good event: fe with cnt==FRAME_C4-1. Bad event: fe with any other cnt. Miss: cnt==FRAME_C4-1 with no fe.
- Sync FSM, states HUNT, CHECK, LOCKED:
  - HUNT: any fe -> CHECK, good_cnt=0.
  - CHECK: good event -> good_cnt+1; at LOCK_FRAMES -> LOCKED, miss_cnt=0. Bad event -> good_cnt=0, stay in CHECK. Miss -> HUNT.
  - LOCKED: good event -> miss_cnt=0. Bad event or miss -> miss_cnt+1; at LOSS_FRAMES -> HUNT. A bad event still realigns cnt to 0.
- All outputs are registered.
  - chan_num and bit_num decode cnt.
  - shift_en = locked && win_active && cnt[0]==1, giving one pulse per bit at mid-bit.
  - frame_start is produced whether locked or not.
- Interrupt:
  - frm_cnt advances at each frame end (cnt==FRAME_C4-1 or fe) while LOCKED.
  - At the wrap INT_DIV-1 -> 0, an interrupt event is generated.
  - Event sets cpu_int=1. int_ack=1 clears cpu_int and int_ovr.
  - Event while cpu_int=1 and int_ack=0 sets int_ovr.
  - Event and int_ack in the same cycle: cpu_int stays 1, int_ovr=0.
- Leaving LOCKED: frm_cnt=0 and shift_en is forced low next cycle. cpu_int and int_ovr are held until acknowledged.
- Reset mid-frame: everything returns to reset values immediately; the next fe restarts the HUNT sequence.

Optional Feature:
- Macro: ST_FRAME_ERR_CNT_EN.
- Defined: adds output err_cnt (8 bits, reset 0). It increments on every bad event or miss in CHECK or LOCKED, saturates at 255, and is cleared by int_ack.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then f0 low for 1 cycle every 512 c4 cycles -> locked=1 after the 3rd pulse (HUNT->CHECK, 2 good), frame_start every 512 cycles, chan_num 0..31.
- Locked, count shift_en pulses per frame -> exactly 192 (24 ch x 8 bits), first at cnt=1, last at cnt=383, none at even cnt.
- Locked, int_ack=0 for 16 frames -> cpu_int rises after 8 frames; int_ovr=1 after frame 16; int_ack for 1 cycle -> both 0.
- Locked, suppress one f0 -> stays locked, frame_start still at cnt=0. Suppress two consecutive -> locked=0, shift_en stops, state HUNT.
- Locked, inject f0 at cnt=100 -> cnt realigns to 0, miss_cnt=1, still locked; with ST_FRAME_ERR_CNT_EN, err_cnt=1.
- Assert reset_rg at cnt=200 with cpu_int=1 -> all outputs 0 asynchronously; relock needs 3 pulses.
